// File: rtl/adc3wire_pkg.sv
// Shared constants, state encoding and word framing for the KAT ADC 3-wire transmitter.
package adc3wire_pkg;

    localparam logic [11:0] ADC3WIRE_HDR    = 12'h001;
    localparam int          ADC3WIRE_WORD_W = 32;
    localparam int          ADC3WIRE_BIT_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_GAP      = 3'd4
    } adc3wire_state_e;

    function automatic logic [ADC3WIRE_WORD_W-1:0] adc3wire_frame(
        input logic [3:0]  addr,
        input logic [15:0] data
    );
        return {ADC3WIRE_HDR, addr, data};
    endfunction

endpackage

// File: rtl/adc3wire_phase_tmr.sv
// Phase timer: reloads to CLK_DIV-1 and counts down; tc is high while the count is zero.
module adc3wire_phase_tmr #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tc
);

    localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] count_r;

    // Down-counter: a reload wins, otherwise decrement until zero and hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CW'(0);
        end else if (load) begin
            count_r <= RELOAD;
        end else if (count_r != CW'(0)) begin
            count_r <= count_r - CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == CW'(0));

endmodule

// File: rtl/adc3wire_tx.sv
// KAT ADC 3-wire serial configuration transmitter: frames {hdr,addr,data} and shifts it MSB first.
// Optional ADC3WIRE_SHADOW_EN adds last_word, the most recently completed framed word.
module adc3wire_tx
    import adc3wire_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int STROBE_GAP = 2
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        busy,
    output logic        done,
    output logic        adc3wire_clk,
    output logic        adc3wire_data,
    output logic        adc3wire_strobe
`ifdef ADC3WIRE_SHADOW_EN
    ,
    output logic [31:0] last_word
`endif
);

    localparam int                        GAP_PH   = 2 * STROBE_GAP;
    localparam int                        GW       = (GAP_PH > 1) ? $clog2(GAP_PH) : 1;
    localparam logic [GW-1:0]             GAP_LAST = GW'(GAP_PH - 1);
    localparam logic [ADC3WIRE_BIT_W-1:0] BIT_LAST = ADC3WIRE_BIT_W'(ADC3WIRE_WORD_W - 1);

    adc3wire_state_e              state_r;
    logic [ADC3WIRE_WORD_W-1:0]   shift_r;
    logic [ADC3WIRE_WORD_W-1:0]   word_s;
    logic [ADC3WIRE_BIT_W-1:0]    bit_cnt_r;
    logic [GW-1:0]                gap_cnt_r;
    logic                         ready_r;
    logic                         busy_r;
    logic                         done_r;
    logic                         sclk_r;
    logic                         strobe_r;
    logic                         accept_s;
    logic                         load_s;
    logic                         gap_exit_s;
    logic                         tc_s;

    assign word_s = adc3wire_frame(cmd_addr, cmd_data);

    adc3wire_phase_tmr #(
        .CLK_DIV (CLK_DIV)
    ) u_tmr (
        .clk   (OPB_Clk),
        .rst_n (OPB_Rst_n),
        .load  (load_s),
        .tc    (tc_s)
    );

    // Acceptance, timer reload at every phase boundary, and end-of-gap detection
    always_comb begin
        accept_s   = 1'b0;
        load_s     = 1'b0;
        gap_exit_s = 1'b0;
        if (state_r == ST_IDLE) begin
            accept_s = cmd_valid & ready_r;
            load_s   = accept_s;
        end else begin
            load_s     = tc_s;
            gap_exit_s = (state_r == ST_GAP) && tc_s && (gap_cnt_r == GAP_LAST);
        end
    end

    // Transmit FSM; the data pin is the shift register MSB, which has shifted to zero by the gap
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_r   <= ST_IDLE;
            shift_r   <= {ADC3WIRE_WORD_W{1'b0}};
            bit_cnt_r <= ADC3WIRE_BIT_W'(0);
            gap_cnt_r <= GW'(0);
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            sclk_r    <= 1'b0;
            strobe_r  <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b1;
                    if (accept_s) begin
                        shift_r   <= word_s;
                        bit_cnt_r <= ADC3WIRE_BIT_W'(0);
                        gap_cnt_r <= GW'(0);
                        ready_r   <= 1'b0;
                        busy_r    <= 1'b1;
                        strobe_r  <= 1'b0;
                        sclk_r    <= 1'b0;
                        state_r   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tc_s) begin
                        sclk_r  <= 1'b1;
                        state_r <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tc_s) begin
                        sclk_r  <= 1'b0;
                        shift_r <= {shift_r[ADC3WIRE_WORD_W-2:0], 1'b0};
                        state_r <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tc_s) begin
                        if (bit_cnt_r == BIT_LAST) begin
                            strobe_r  <= 1'b1;
                            shift_r   <= {ADC3WIRE_WORD_W{1'b0}};
                            gap_cnt_r <= GW'(0);
                            state_r   <= ST_GAP;
                        end else begin
                            sclk_r    <= 1'b1;
                            bit_cnt_r <= bit_cnt_r + ADC3WIRE_BIT_W'(1);
                            state_r   <= ST_SHIFT_HI;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_exit_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end else if (tc_s) begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                    end
                end
                default: begin
                    shift_r  <= {ADC3WIRE_WORD_W{1'b0}};
                    ready_r  <= 1'b0;
                    busy_r   <= 1'b0;
                    sclk_r   <= 1'b0;
                    strobe_r <= 1'b1;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready       = ready_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign adc3wire_clk    = sclk_r;
    assign adc3wire_data   = shift_r[ADC3WIRE_WORD_W-1];
    assign adc3wire_strobe = strobe_r;

`ifdef ADC3WIRE_SHADOW_EN
    logic [ADC3WIRE_WORD_W-1:0] frame_r;
    logic [ADC3WIRE_WORD_W-1:0] last_word_r;

    // Hold the accepted word and publish it only when its frame completes
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            frame_r     <= {ADC3WIRE_WORD_W{1'b0}};
            last_word_r <= {ADC3WIRE_WORD_W{1'b0}};
        end else begin
            if (accept_s) begin
                frame_r <= word_s;
            end
            if (gap_exit_s) begin
                last_word_r <= frame_r;
            end
        end
    end

    assign last_word = last_word_r;
`endif

endmodule

// File: tb/tb_adc3wire_tx.sv
// Self-checking bench for adc3wire_tx: vector table, random commands vs. a word/timing model, corner sequences.
module tb_adc3wire_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1, valid = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [15:0] data = 16'h0;
    logic        ready, busy, done, sclk, sdata, strobe;

    logic        rst2_n = 1'b1, valid2 = 1'b0;
    logic [3:0]  addr2 = 4'h0;
    logic [15:0] data2 = 16'h0;
    logic        ready2, busy2, done2, sclk2, sdata2, strobe2;
`ifdef ADC3WIRE_SHADOW_EN
    logic [31:0] last_word, last_word2;
`endif

    int errors = 0;
    int checks = 0;

    adc3wire_tx #(.CLK_DIV(4), .STROBE_GAP(2)) dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .cmd_valid(valid), .cmd_ready(ready),
        .cmd_addr(addr), .cmd_data(data), .busy(busy), .done(done),
        .adc3wire_clk(sclk), .adc3wire_data(sdata), .adc3wire_strobe(strobe)
`ifdef ADC3WIRE_SHADOW_EN
        , .last_word(last_word)
`endif
    );

    adc3wire_tx #(.CLK_DIV(1), .STROBE_GAP(1)) dut2 (
        .OPB_Clk(clk), .OPB_Rst_n(rst2_n), .cmd_valid(valid2), .cmd_ready(ready2),
        .cmd_addr(addr2), .cmd_data(data2), .busy(busy2), .done(done2),
        .adc3wire_clk(sclk2), .adc3wire_data(sdata2), .adc3wire_strobe(strobe2)
`ifdef ADC3WIRE_SHADOW_EN
        , .last_word(last_word2)
`endif
    );

    // Bus monitor: word captured on serial-clock rising edges while the strobe is low
    logic [31:0] cap = 32'h0;
    int ncap = 0, bad_edges = 0, frames = 0;
    always @(negedge strobe) begin cap = 32'h0; ncap = 0; frames++; end
    always @(posedge sclk) begin
        if (strobe === 1'b0) begin cap = {cap[30:0], sdata}; ncap++; end
        else bad_edges++;
    end

    // Strobe-high run lengths in system cycles, total and the part while busy
    int hi_run = 0, hib_run = 0, last_hi_run = 0, last_hib_run = 0;
    always @(negedge clk) begin
        if (strobe === 1'b1) begin
            hi_run++;
            if (busy === 1'b1) hib_run++;
        end else begin
            if (hi_run != 0) begin last_hi_run = hi_run; last_hib_run = hib_run; end
            hi_run = 0;
            hib_run = 0;
        end
    end

    logic [31:0] cap2 = 32'h0;
    int ncap2 = 0, bad_edges2 = 0;
    longint t_prev2 = 0, per2 = 0;
    always @(negedge strobe2) begin cap2 = 32'h0; ncap2 = 0; end
    always @(posedge sclk2) begin
        if (strobe2 === 1'b0) begin cap2 = {cap2[30:0], sdata2}; ncap2++; end
        else bad_edges2++;
        if (t_prev2 != 0) per2 = $time - t_prev2;
        t_prev2 = $time;
    end

    // Reference model: framing rule and latency from phase counts
    function automatic logic [31:0] model_word(input logic [3:0] a, input logic [15:0] d);
        return (32'h001 << 20) | (32'(a) << 16) | 32'(d);
    endfunction

    function automatic int model_lat(input int cd, input int sg);
        return cd + 2 * 32 * cd + 2 * cd * sg;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic frame(input logic [3:0] a, input logic [15:0] d, input bit hold,
                         input logic [3:0] na, input logic [15:0] nd,
                         output logic [31:0] word, output int nedge, output int lat, output int waitc);
        @(negedge clk);
        valid = 1'b1; addr = a; data = d;
        waitc = 0;
        while (ready !== 1'b1 && waitc < 2000) begin @(negedge clk); waitc++; end
        @(posedge clk); #1;
        if (hold) begin addr = na; data = nd; end
        else valid = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 2000) begin @(posedge clk); #1; lat++; end
        word = cap;
        nedge = ncap;
    endtask

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
        logic [31:0] w;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [31:0] w;
        int ne, lat, wc, n, fr;
        logic [3:0] ra;
        logic [15:0] rd;

        vecs[0] = '{4'h9, 16'hdead, 32'h0019dead};
        vecs[1] = '{4'h0, 16'h0000, 32'h00100000};
        vecs[2] = '{4'hF, 16'hFFFF, 32'h001FFFFF};
        vecs[3] = '{4'h5, 16'hA5A5, 32'h0015A5A5};

        #1 rst_n = 1'b0; rst2_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_clk", 32'(sclk), 32'h0);
        check("rst_data", 32'(sdata), 32'h0);
        check("rst_strobe", 32'(strobe), 32'h1);
        rst_n = 1'b1; rst2_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(ready), 32'h1);

        for (int i = 0; i < 4; i++) begin
            frame(vecs[i].a, vecs[i].d, 1'b0, 4'h0, 16'h0, w, ne, lat, wc);
            check("vec_word", w, vecs[i].w);
            check("vec_edges", 32'(ne), 32'd32);
            check("vec_latency", 32'(lat), 32'd276);
            check("vec_idle_edges", 32'(bad_edges), 32'd0);
`ifdef ADC3WIRE_SHADOW_EN
            check("shadow_word", last_word, vecs[i].w);
`endif
        end

        for (int i = 0; i < 5; i++) begin
            ra = 4'($urandom_range(0, 15));
            rd = 16'($urandom_range(0, 65535));
            frame(ra, rd, 1'b0, 4'h0, 16'h0, w, ne, lat, wc);
            check("rand_word", w, model_word(ra, rd));
            check("rand_edges", 32'(ne), 32'd32);
            check("rand_latency", 32'(lat), 32'(model_lat(4, 2)));
        end

        // Back-to-back: second command held valid throughout the first frame
        frame(4'h9, 16'hdead, 1'b1, 4'h8, 16'hbeef, w, ne, lat, wc);
        check("b2b_first_word", w, 32'h0019dead);
        check("b2b_first_latency", 32'(lat), 32'd276);
`ifdef ADC3WIRE_SHADOW_EN
        check("b2b_shadow", last_word, 32'h0019dead);
`endif
        frame(4'h8, 16'hbeef, 1'b0, 4'h0, 16'h0, w, ne, lat, wc);
        check("b2b_accept_on_done", 32'(wc), 32'd0);
        check("b2b_second_word", w, 32'h0018beef);
        check("b2b_second_latency", 32'(lat), 32'd276);
        // 16 gap cycles while busy, plus the done cycle on which the next command is taken
        check("b2b_gap_busy", 32'(last_hib_run), 32'd16);
        check("b2b_gap_total", 32'(last_hi_run), 32'd17);

        // Differing command pulsed while busy must be ignored
        fr = frames;
        fork
            frame(4'h6, 16'h1357, 1'b0, 4'h0, 16'h0, w, ne, lat, wc);
            begin
                repeat (40) @(negedge clk);
                valid = 1'b1; addr = 4'h3; data = 16'h1234;
                repeat (3) @(negedge clk);
                valid = 1'b0;
            end
        join
        check("busy_pulse_word", w, 32'h00161357);
        repeat (40) @(negedge clk);
        check("busy_pulse_frames", 32'(frames - fr), 32'd1);
        check("busy_pulse_idle", 32'(busy), 32'h0);

        // Reset after the 10th serial clock edge aborts the frame asynchronously
        @(negedge clk);
        valid = 1'b1; addr = 4'hC; data = 16'h3333;
        n = 0;
        while (ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        valid = 1'b0;
        n = 0;
        while (ncap < 10 && n < 2000) begin @(posedge clk); #1; n++; end
        check("abort_reached_10", 32'(ncap), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        check("abort_strobe", 32'(strobe), 32'h1);
        check("abort_clk", 32'(sclk), 32'h0);
        check("abort_ready", 32'(ready), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
`ifdef ADC3WIRE_SHADOW_EN
        check("abort_shadow", last_word, 32'h0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_ready_after", 32'(ready), 32'h1);
        frame(4'h1, 16'h0001, 1'b0, 4'h0, 16'h0, w, ne, lat, wc);
        check("abort_next_word", w, 32'h00110001);
        check("abort_next_edges", 32'(ne), 32'd32);
        check("abort_next_latency", 32'(lat), 32'd276);
        check("idle_edges_total", 32'(bad_edges), 32'd0);

        // CLK_DIV=1, STROBE_GAP=1 instance
        @(negedge clk);
        valid2 = 1'b1; addr2 = 4'hF; data2 = 16'hFFFF;
        n = 0;
        while (ready2 !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        valid2 = 1'b0;
        lat = 0;
        while (done2 !== 1'b1 && lat < 2000) begin @(posedge clk); #1; lat++; end
        check("div1_word", cap2, 32'h001FFFFF);
        check("div1_edges", 32'(ncap2), 32'd32);
        check("div1_latency", 32'(lat), 32'(model_lat(1, 1)));
        check("div1_period", 32'(per2), 32'd20);
        check("div1_idle_edges", 32'(bad_edges2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
